// File: rtl/branch_predictor_pkg.sv
// Shared control definitions for the branch predictor: counter encodings
// and default table geometry.
package branch_predictor_pkg;

   localparam int IDX_W_DEF = 6;
   localparam int TAG_W_DEF = 8;

   // 2-bit saturating direction counter encodings
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,   // strongly not taken
      CTR_WNT = 2'b01,   // weakly not taken
      CTR_WT  = 2'b10,   // weakly taken
      CTR_ST  = 2'b11    // strongly taken
   } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Priority: a jump forces strongly-taken, a fresh allocation starts at
// weakly-taken, otherwise the counter steps toward the actual outcome.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   input  logic       i_alloc,
   input  logic       i_force_st,
   output logic [1:0] o_ctr
);

   // saturating increment/decrement with allocate and force overrides
   always_comb begin
      o_ctr = i_ctr;
      if (i_force_st) begin
         o_ctr = CTR_ST;
      end else if (i_alloc) begin
         o_ctr = CTR_WT;
      end else if (i_taken) begin
         if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
      end else begin
         if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is purely combinational; updates from execute land on the clock
// edge, so a same-cycle lookup of the updated entry sees the old contents.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        predict_taken_o,
   output logic [31:0] predict_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   input  logic        upd_is_jump_i,
   input  logic        upd_mispredict_i,
   output logic [31:0] mispredict_cnt_o
);

   localparam int DEPTH  = 1 << IDX_W;
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = TAG_LO + TAG_W - 1;

   // Valid bits are individual flops (cleared by reset); the payload fields
   // are plain arrays that never need resetting.
   logic             r_valid      [DEPTH];
   logic [TAG_W-1:0] r_tag_mem    [DEPTH];
   logic [31:0]      r_target_mem [DEPTH];
   logic [1:0]       r_ctr_mem    [DEPTH];
   logic [31:0]      r_mispredict_cnt;

   logic [IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic             w_lk_hit;

   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic             w_up_write;
   logic             w_up_alloc;
   logic             w_up_wr_target;
   logic [1:0]       w_up_ctr_next;

   // PC bits below the word offset and above the tag never take part.
   logic             w_unused_bits;
   assign w_unused_bits = ^{pc_i[1:0], pc_i[31:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[31:TAG_HI+1]};

   // ---------------- fetch-side lookup ----------------
   assign w_lk_idx = pc_i[IDX_W+1:2];
   assign w_lk_tag = pc_i[TAG_HI:TAG_LO];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag_mem[w_lk_idx] == w_lk_tag);

   // prediction outputs: fall through to pc+4 on a miss
   always_comb begin
      predict_taken_o  = 1'b0;
      predict_target_o = pc_i + 32'd4;
      if (w_lk_hit) begin
         predict_taken_o  = r_ctr_mem[w_lk_idx][1];
         predict_target_o = r_target_mem[w_lk_idx];
      end
   end

   // ---------------- execute-side update ----------------
   assign w_up_idx = upd_pc_i[IDX_W+1:2];
   assign w_up_tag = upd_pc_i[TAG_HI:TAG_LO];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag_mem[w_up_idx] == w_up_tag);

   // A not-taken miss leaves the table alone; anything else writes the entry.
   // Reset takes priority, so no table write happens while rst is high.
   assign w_up_write     = !rst && upd_valid_i && (w_up_hit || upd_taken_i);
   assign w_up_alloc     = w_up_write && !w_up_hit;
   assign w_up_wr_target = w_up_write && upd_taken_i;

   sat_counter2 u_sat_counter2 (
      .i_ctr      (r_ctr_mem[w_up_idx]),
      .i_taken    (upd_taken_i),
      .i_alloc    (!w_up_hit),
      .i_force_st (upd_is_jump_i),
      .o_ctr      (w_up_ctr_next)
   );

   // per-entry valid flops: cleared on reset, set on allocation
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid[gi] <= 1'b0;
            end else if (w_up_alloc && (w_up_idx == IDX_W'(gi))) begin
               r_valid[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   // payload array write: tag on allocation, target on taken, counter always
   always_ff @(posedge clk) begin
      if (w_up_write) begin
         r_ctr_mem[w_up_idx] <= w_up_ctr_next;
         if (w_up_alloc)     r_tag_mem[w_up_idx]    <= w_up_tag;
         if (w_up_wr_target) r_target_mem[w_up_idx] <= upd_target_i;
      end
   end

   // misprediction counter, wraps naturally at 2**32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mispredict_cnt <= '0;
      end else if (upd_valid_i && upd_mispredict_i) begin
         r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
   end

   assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning table index width; the table holds 2**IDX_W entries.
REQ-002 SHALL have parameter TAG_W, default 8, meaning tag width, taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pc_i, input, 32 bits: fetch PC to look up.
REQ-006 SHALL have port predict_taken_o, output, 1 bit: predicted taken for pc_i.
REQ-007 SHALL have port predict_target_o, output, 32 bits: predicted target for pc_i.
REQ-008 SHALL have port upd_valid_i, input, 1 bit: a resolved control-transfer instruction is present in execute.
REQ-009 SHALL have port upd_pc_i, input, 32 bits: PC of the resolved instruction.
REQ-010 SHALL have port upd_taken_i, input, 1 bit: actual branch outcome.
REQ-011 SHALL have port upd_target_i, input, 32 bits: actual taken target.
REQ-012 SHALL have port upd_is_jump_i, input, 1 bit: resolved instruction is JAL (unconditional).
REQ-013 SHALL have port upd_mispredict_i, input, 1 bit: execute flagged a prediction miss.
REQ-014 SHALL have port mispredict_cnt_o, output, 32 bits: count of mispredictions since reset.

Function
REQ-015 SHALL give each entry a valid bit, a TAG_W tag, a 32-bit target and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-016 SHALL perform lookup combinationally with zero latency: index = pc_i[IDX_W+1:2]; hit = valid & tag match.
REQ-017 SHALL drive predict_taken_o = hit & counter[1] and predict_target_o = target on a hit; on a miss, predict_taken_o=0 and predict_target_o=pc_i+4.
REQ-018 SHALL apply updates at the clock edge when upd_valid_i=1, indexed by upd_pc_i.
REQ-019 On an update that hits, SHALL increment the counter (saturate at 11) if taken, decrement it (saturate at 00) if not taken, and rewrite the target if taken.
REQ-020 On an update that misses with upd_taken_i=1, SHALL allocate the entry, overwriting any prior occupant: valid=1, tag, target, counter=10.
REQ-021 On an update that misses with upd_taken_i=0, SHALL leave the table unchanged.
REQ-022 When upd_is_jump_i=1, SHALL force the counter to 11 whether the update hits or allocates.
REQ-023 When a lookup and an update hit the same index in one cycle, SHALL return the pre-update (old) contents; there is no bypass.
REQ-024 SHALL increment mispredict_cnt_o by 1 on each cycle with upd_valid_i & upd_mispredict_i, wrapping from 0xFFFFFFFF to 0.
REQ-025 SHALL ignore upd_taken_i, upd_is_jump_i and upd_mispredict_i when upd_valid_i=0.

Reset
REQ-026 While rst=1, SHALL clear all valid bits and mispredict_cnt_o in one cycle; tags, targets and counters need not be reset.
REQ-027 SHALL give rst priority over a simultaneous update; after rst the first lookup SHALL miss (predict_taken_o=0, target=pc_i+4).

Structure
REQ-028 SHALL place the counter encodings (SNT/WNT/WT/ST) and the default IDX_W/TAG_W constants in the shared control header used by the core.
REQ-029 SHALL implement the 2-bit saturating-counter next-state as one sub-module, sat_counter2; valid bits as flops, remaining fields as an array.

Verification
REQ-030 After rst, set pc_i=0x100 -> predict_taken_o=0 and predict_target_o=0x104.
REQ-031 Update pc=0x100, taken=1, target=0x80 -> next cycle, lookup 0x100 returns taken=1 and target 0x80 with counter 10; two not-taken updates -> taken=0 (counter 00); a further not-taken update keeps 00.
REQ-032 Allocate 0x100 and then update 0x4100 (same index, different tag) with taken=1 -> lookup 0x100 misses; lookup 0x4100 hits.
REQ-033 JAL update pc=0x200, is_jump=1, target=0x300 -> counter 11; one not-taken update -> still predicted taken (counter 10).
REQ-034 Update and lookup the same PC in the same cycle -> old prediction returned that cycle, new prediction the following cycle.
REQ-035 Three mispredict updates, then rst asserted mid-stream with a simultaneous update -> mispredict_cnt_o reads 3, then 0, and the table misses.
